// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver: walks all 2^N_IN input vectors through a logic cell and collects its truth table.
// Defining TT_SWEEP_CHECK_EN adds exp_table comparison with pass/fail_cnt/first_fail outputs.
module tt_sweep_driver #(
    parameter int N_IN       = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      stim,
    input  logic                 resp,
`ifdef TT_SWEEP_CHECK_EN
    input  logic [2**N_IN-1:0]   exp_table,
    output logic                 pass,
    output logic [N_IN:0]        fail_cnt,
    output logic [N_IN-1:0]      first_fail,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out
);
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_e;
    // one extra index bit keeps the last-vector compare free of wrap-around
    localparam logic [N_IN:0] LAST   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] ONE    = (N_IN+1)'(1);
    localparam logic [7:0]    SETTLE = 8'(SETTLE_CYC);
    localparam state_e        FIRST  = (SETTLE_CYC == 0) ? SAMPLE : HOLD;

    state_e                state_q, state_d;
    logic [N_IN:0]         stim_q, stim_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2**N_IN-1:0]    table_q, table_d;
`ifdef TT_SWEEP_CHECK_EN
    logic                  pass_q, pass_d;
    logic [N_IN:0]         fail_q, fail_d;
    logic [N_IN-1:0]       first_q, first_d;

    assign pass       = pass_q;
    assign fail_cnt   = fail_q;
    assign first_fail = first_q;
`endif

    assign stim      = stim_q[N_IN-1:0];
    assign busy      = (state_q == HOLD) || (state_q == SAMPLE);
    assign done      = state_q == DONE;
    assign table_out = table_q;

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        table_d = table_q;
`ifdef TT_SWEEP_CHECK_EN
        pass_d  = pass_q;
        fail_d  = fail_q;
        first_d = first_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = FIRST;
                stim_d  = '0;
                cnt_d   = SETTLE;
                table_d = '0;
`ifdef TT_SWEEP_CHECK_EN
                pass_d  = 1'b0;
                fail_d  = '0;
                first_d = '0;
`endif
            end
            HOLD: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? SAMPLE : HOLD;
            end
            SAMPLE: begin
                table_d[stim] = resp;
                state_d       = (stim_q == LAST) ? DONE : FIRST;
                if (stim_q != LAST) begin
                    stim_d = stim_q + ONE;
                    cnt_d  = SETTLE;
                end
`ifdef TT_SWEEP_CHECK_EN
                if (resp != exp_table[stim]) begin
                    fail_d = fail_q + ONE;
                    if (fail_q == '0) first_d = stim;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
`ifdef TT_SWEEP_CHECK_EN
                pass_d  = fail_q == '0;
`endif
            end
            default: state_d = IDLE;
        endcase
        // abort overrides the sample write and the vector increment
        if (abort && busy) begin
            state_d = IDLE;
            stim_d  = '0;
            table_d = '0;
`ifdef TT_SWEEP_CHECK_EN
            pass_d  = 1'b0;
            fail_d  = '0;
            first_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            table_q <= '0;
`ifdef TT_SWEEP_CHECK_EN
            pass_q  <= 1'b0;
            fail_q  <= '0;
            first_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
`ifdef TT_SWEEP_CHECK_EN
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            first_q <= first_d;
`endif
        end
    end
endmodule

// File: tb/tb_tt_sweep_driver.sv
// tb_tt_sweep_driver: directed bench for tt_sweep_driver (SETTLE_CYC=1 and SETTLE_CYC=0 instances).
module tb_tt_sweep_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [3:0]  stim, stim1;
    logic        resp, resp1;
    logic        busy, done, busy1, done1;
    logic [15:0] tbl, tbl1;
    int          mode = 0;
    int          passed = 0;
    int          total = 0;
`ifdef TT_SWEEP_CHECK_EN
    logic [15:0] exp_t = 16'h2000;
    logic        pass, pass1;
    logic [4:0]  fail_cnt, fail_cnt1;
    logic [3:0]  first_fail, first_fail1;
`endif

    always #5 clk = ~clk;

    // cell models: 0 = a&b&~c&d, 1 = d, 2 = minterm 1101 with a stuck-1 at vector 3
    assign resp  = (mode == 1) ? stim[0] : ((stim == 4'hd) || (mode == 2 && stim == 4'h3));
    assign resp1 = stim1[0];

    tt_sweep_driver #(.N_IN(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim), .resp(resp),
`ifdef TT_SWEEP_CHECK_EN
        .exp_table(exp_t), .pass(pass), .fail_cnt(fail_cnt), .first_fail(first_fail),
`endif
        .busy(busy), .done(done), .table_out(tbl)
    );

    tt_sweep_driver #(.N_IN(4), .SETTLE_CYC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .stim(stim1), .resp(resp1),
`ifdef TT_SWEEP_CHECK_EN
        .exp_table(16'haaaa), .pass(pass1), .fail_cnt(fail_cnt1), .first_fail(first_fail1),
`endif
        .busy(busy1), .done(done1), .table_out(tbl1)
    );

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, stim, tbl} !== 22'd0) $display("FAIL reset dut busy=%b done=%b stim=%h table=%h want all 0", busy, done, stim, tbl);
        else passed++;
        total++;
        if ({busy1, done1, stim1, tbl1} !== 22'd0) $display("FAIL reset dut1 busy=%b done=%b stim=%h table=%h want all 0", busy1, done1, stim1, tbl1);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default_sweep();
        mode = 0;
        start_pulse();
        for (int c = 1; c <= 34; c++) begin
            total++;
            if (busy !== (c <= 32) || done !== (c == 33) || (c <= 32 && stim !== 4'((c - 1) / 2)))
                $display("FAIL default_timing cycle=%0d busy=%b done=%b stim=%h want busy=%b done=%b stim=%h",
                         c, busy, done, stim, c <= 32, c == 33, 4'((c - 1) / 2));
            else passed++;
            if (c < 34) @(negedge clk);
        end
        total++;
        if (tbl !== 16'h2000) $display("FAIL default_table got=%h want=2000", tbl);
        else passed++;
    endtask

    task automatic test_settle0();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            total++;
            if (busy1 !== (c <= 16) || done1 !== (c == 17) || (c <= 16 && stim1 !== 4'(c - 1)))
                $display("FAIL settle0_timing cycle=%0d busy=%b done=%b stim=%h want busy=%b done=%b stim=%h",
                         c, busy1, done1, stim1, c <= 16, c == 17, 4'(c - 1));
            else passed++;
            if (c < 18) @(negedge clk);
        end
        total++;
        if (tbl1 !== 16'haaaa) $display("FAIL settle0_table got=%h want=aaaa", tbl1);
        else passed++;
    endtask

    task automatic test_abort();
        logic saw_done = 1'b0;
        int   n;
        mode = 1;
        start_pulse();
        repeat (9) @(negedge clk);
        total++;
        if (tbl !== 16'h000a || busy !== 1'b1 || stim !== 4'h4)
            $display("FAIL abort_pre table=%h busy=%b stim=%h want table=000a busy=1 stim=4", tbl, busy, stim);
        else passed++;
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        total++;
        if ({busy, done, stim, tbl} !== 22'd0)
            $display("FAIL abort_post busy=%b done=%b stim=%h table=%h want all 0", busy, done, stim, tbl);
        else passed++;
        for (int c = 0; c < 40; c++) begin
            saw_done |= done | busy;
            @(negedge clk);
        end
        total++;
        if (saw_done !== 1'b0) $display("FAIL abort_no_done activity=%b want 0", saw_done);
        else passed++;
        start_pulse();
        for (n = 0; n < 40 && done !== 1'b1; n++) @(negedge clk);
        total++;
        if (done !== 1'b1 || tbl !== 16'haaaa)
            $display("FAIL abort_rerun done=%b table=%h want done=1 table=aaaa", done, tbl);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 35; c++) begin
            total++;
            if (busy !== (c <= 32 || c == 35) || done !== (c == 33))
                $display("FAIL b2b_timing cycle=%0d busy=%b done=%b want busy=%b done=%b", c, busy, done, c <= 32 || c == 35, c == 33);
            else passed++;
            if (c == 20) begin
                total++;
                if (stim !== 4'h9) $display("FAIL b2b_no_restart stim=%h want 9", stim);
                else passed++;
            end
            if (c == 33 || c == 34) begin
                total++;
                if (tbl !== 16'h2000) $display("FAIL b2b_gap_table cycle=%0d table=%h want 2000", c, tbl);
                else passed++;
            end
            if (c == 35) begin
                total++;
                if (tbl !== 16'h0000 || stim !== 4'h0) $display("FAIL b2b_restart table=%h stim=%h want 0000/0", tbl, stim);
                else passed++;
            end
            if (c < 35) @(negedge clk);
        end
        start = 1'b0;
        for (n = 0; n < 40 && done !== 1'b1; n++) @(negedge clk);
        total++;
        if (done !== 1'b1 || tbl !== 16'h2000) $display("FAIL b2b_second done=%b table=%h want 1/2000", done, tbl);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic act = 1'b0;
        mode = 1;
        start_pulse();
        repeat (6) @(negedge clk);
        total++;
        if (tbl !== 16'h0002 || busy !== 1'b1 || stim !== 4'h3)
            $display("FAIL rst_pre table=%h busy=%b stim=%h want 0002/1/3", tbl, busy, stim);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, stim, tbl} !== 22'd0)
            $display("FAIL rst_async busy=%b done=%b stim=%h table=%h want all 0", busy, done, stim, tbl);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            act |= done | busy;
            @(negedge clk);
        end
        total++;
        if (act !== 1'b0) $display("FAIL rst_no_done activity=%b want 0", act);
        else passed++;
    endtask

`ifdef TT_SWEEP_CHECK_EN
    task automatic test_check();
        int n;
        for (int k = 0; k < 2; k++) begin
            mode = (k == 0) ? 2 : 0;
            start_pulse();
            for (n = 0; n < 40 && done !== 1'b1; n++) @(negedge clk);
            @(negedge clk);
            total++;
            if (k == 0 && (pass !== 1'b0 || fail_cnt !== 5'd1 || first_fail !== 4'h3 || tbl !== 16'h2008))
                $display("FAIL check_mismatch pass=%b fail_cnt=%0d first_fail=%h table=%h want 0/1/3/2008", pass, fail_cnt, first_fail, tbl);
            else if (k == 1 && (pass !== 1'b1 || fail_cnt !== 5'd0 || first_fail !== 4'h0 || tbl !== 16'h2000))
                $display("FAIL check_match pass=%b fail_cnt=%0d first_fail=%h table=%h want 1/0/0/2000", pass, fail_cnt, first_fail, tbl);
            else passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_sweep();
        test_settle0();
        test_abort();
        test_back_to_back();
`ifdef TT_SWEEP_CHECK_EN
        test_check();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
